// File: rtl/hmmm_pkg.sv
// Shared constants and FSM state encodings for the HMMM program loader.
package hmmm_pkg;

    localparam int WORD_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int RAM_DEPTH  = 256;
    localparam int CLR_CYCLES = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CLR    = 3'd1;
    localparam state_t S_ADDR   = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_RUN    = 3'd4;
    localparam state_t S_HALTED = 3'd5;
    localparam state_t S_ERR    = 3'd6;

endpackage

// File: rtl/hmmm_edge_detect.sv
// Registered rising-edge detector: pulses for the first cycle its input is high.
module hmmm_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/hmmm_loader.sv
// Streams a program image into an HMMM CPU over its io bus, then bridges the
// CPU's io reads and writes to host streams until the CPU halts.
module hmmm_loader #(
    parameter int WORD_W = hmmm_pkg::WORD_W,
    parameter int ADDR_W = hmmm_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              img_valid,
    output logic              img_ready,
    input  logic [WORD_W-1:0] img_data,
    input  logic              img_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              cpu_rst,
    output logic              cpu_pgrm_addr,
    output logic              cpu_pgrm_data,
    output logic [WORD_W-1:0] cpu_io_out,
    output logic              cpu_io_oe,
    input  logic [WORD_W-1:0] cpu_io_in,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              underflow,
    output logic [ADDR_W:0]   load_count
);

    import hmmm_pkg::*;

    localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

    state_t             state_q,      state_d;
    logic [1:0]         clr_cnt_q,    clr_cnt_d;
    logic [ADDR_W:0]    load_count_q, load_count_d;
    logic [WORD_W-1:0]  word_q,       word_d;
    logic               last_q,       last_d;
    logic [WORD_W-1:0]  rd_word_q,    rd_word_d;
    logic               underflow_q,  underflow_d;
    logic               out_valid_q,  out_valid_d;
    logic [WORD_W-1:0]  out_data_q,   out_data_d;
    logic               rd_rise;
    logic               wr_rise;

    hmmm_edge_detect u_rd_edge (.clk(clk), .rst(rst), .sig_i(cpu_read),  .rise_o(rd_rise));
    hmmm_edge_detect u_wr_edge (.clk(clk), .rst(rst), .sig_i(cpu_write), .rise_o(wr_rise));

    always_comb begin
        // NOTE: every next-state and output gets a default first, so no path can infer a latch.
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        load_count_d  = load_count_q;
        word_d        = word_q;
        last_d        = last_q;
        rd_word_d     = rd_word_q;
        underflow_d   = underflow_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        img_ready     = 1'b0;
        in_ready      = 1'b0;
        cpu_pgrm_addr = 1'b0;
        cpu_pgrm_data = 1'b0;
        cpu_io_oe     = 1'b0;
        cpu_io_out    = '0;

        case (state_q)
            S_IDLE, S_HALTED, S_ERR: begin
                if (start) begin
                    state_d      = S_CLR;
                    clr_cnt_d    = '0;
                    load_count_d = '0;
                    underflow_d  = 1'b0;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_ADDR;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_ADDR: begin
                // A full RAM refuses the next word instead of wrapping the address.
                if (load_count_q[ADDR_W]) begin
                    if (img_valid) begin
                        state_d = S_ERR;
                    end
                end else begin
                    img_ready = 1'b1;
                    if (img_valid) begin
                        word_d        = img_data;
                        last_d        = img_last;
                        cpu_io_out    = WORD_W'(load_count_q[ADDR_W-1:0]);
                        cpu_io_oe     = 1'b1;
                        cpu_pgrm_addr = 1'b1;
                        state_d       = S_DATA;
                    end
                end
            end
            S_DATA: begin
                cpu_io_out    = word_q;
                cpu_io_oe     = 1'b1;
                cpu_pgrm_data = 1'b1;
                load_count_d  = load_count_q + 1'b1;
                state_d       = last_q ? S_RUN : S_ADDR;
            end
            S_RUN: begin
                if (rd_rise) begin
                    if (in_valid) begin
                        in_ready  = 1'b1;
                        rd_word_d = in_data;
                    end else begin
                        rd_word_d   = '0;
                        underflow_d = 1'b1;
                    end
                end
                // rd_word_d bypasses the register so the edge cycle already shows the new word.
                if (cpu_read) begin
                    cpu_io_oe  = 1'b1;
                    cpu_io_out = rd_word_d;
                end
                if (wr_rise) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cpu_io_in;
                end
                if (cpu_halt) begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            load_count_q <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            rd_word_q    <= '0;
            underflow_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            load_count_q <= load_count_d;
            word_q       <= word_d;
            last_q       <= last_d;
            rd_word_q    <= rd_word_d;
            underflow_q  <= underflow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // The CPU is held in reset while this block is, independent of the clock.
    assign cpu_rst    = ~rst | (state_q == S_CLR);
    assign busy       = (state_q == S_CLR) | (state_q == S_ADDR) |
                        (state_q == S_DATA) | (state_q == S_RUN);
    assign done       = (state_q == S_HALTED);
    assign err        = (state_q == S_ERR);
    assign underflow  = underflow_q;
    assign load_count = load_count_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

endmodule

// File: doc/hmmm_loader.md
HMMM_LOADER -- requirements
Module: hmmm_loader

Interface
REQ-001 Parameter: WORD_W, default 16, CPU io and program word width.
REQ-002 Parameter: ADDR_W, default 8, CPU RAM address width (256 words).
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin load-and-run; level sampled per cycle.
REQ-006 img_valid / img_ready / img_data[WORD_W] / img_last  in/out/in/in  program-image stream, valid-ready.
REQ-007 in_valid / in_ready / in_data[WORD_W]  in/out/in  host words for CPU read.
REQ-008 out_valid / out_data[WORD_W]  out/out  word captured from CPU write, 1-cycle pulse.
REQ-009 cpu_rst  out  1  CPU reset, active-high.
REQ-010 cpu_pgrm_addr / cpu_pgrm_data  out  1  CPU program-load strobes.
REQ-011 cpu_io_out[WORD_W] / cpu_io_oe / cpu_io_in[WORD_W]  out/out/in  io bus split; the top level ties these to the tristate pad.
REQ-012 cpu_read / cpu_write / cpu_halt  in  1  CPU io strobes and halt.
REQ-013 busy / done / err / underflow  out  1  status; load_count[ADDR_W+1] out, words loaded.

Function
REQ-014 FSM states: IDLE, CLR, ADDR, DATA, RUN, HALTED, ERR.
REQ-015 IDLE: all strobes low; start=1 -> CLR; clear load_count, underflow, err.
REQ-016 CLR: cpu_rst=1 for exactly 2 cycles -> ADDR.
REQ-017 ADDR: img_ready=1; on img_valid: latch img_data and img_last, drive cpu_io_out = zero-extended load_count[ADDR_W-1:0], cpu_io_oe=1, cpu_pgrm_addr=1 for one cycle -> DATA; with no img_valid, stay in ADDR with strobes low.
REQ-018 DATA: drive cpu_io_out = latched word, cpu_io_oe=1, cpu_pgrm_data=1 for one cycle; load_count+1; latched last -> RUN, else ADDR.
REQ-019 Load throughput: one word per 2 cycles at full img_valid.
REQ-020 Overflow: a 257th word (load_count=256, in ADDR, img_valid) -> ERR without strobing; img_ready=0 in ERR.
REQ-021 RUN: rising edge of cpu_read with in_valid=1: in_ready=1 for that cycle, register in_data; cpu_io_out=registered word, cpu_io_oe=1 while cpu_read is high.
REQ-022 Read with in_valid=0 at the rising edge: drive 0, set sticky underflow, do not consume.
REQ-023 Rising edge of cpu_write: out_data=cpu_io_in, out_valid=1 next cycle only; held cpu_write gives no repeat.
REQ-024 cpu_read and cpu_write rising in the same cycle: both serviced, no io drive conflict (cpu_io_oe follows cpu_read only).
REQ-025 cpu_halt=1 in RUN -> HALTED; a read or write edge in the same cycle is still serviced.
REQ-026 HALTED: done=1. ERR: err=1. In both states, start -> CLR.
REQ-027 start is ignored in CLR, ADDR, DATA and RUN; busy=1 in those states.
REQ-028 cpu_halt is ignored outside RUN; cpu_read and cpu_write are ignored outside RUN.
REQ-029 cpu_io_oe=0 whenever no drive is required by REQ-017/018/021.

Reset
REQ-030 rst low: state IDLE immediately, all outputs 0 except cpu_rst=1, counters and flags cleared, edge detectors cleared.
REQ-031 Reset mid-load or mid-run: discard the partial image; a restart requires start again.

Structure
REQ-032 Shared package hmmm_pkg: state enumeration, WORD_W, ADDR_W, RAM_DEPTH=256, CLR_CYCLES=2.
REQ-033 One sub-module, hmmm_edge_detect: registered rising-edge detector, instanced for cpu_read and cpu_write.

Verification
REQ-034 3-word image 0x1111, 0x2222, 0x3333 (last on third), full valid -> pgrm_addr io values 0, 1, 2 and pgrm_data values as given, 6 cycles after CLR, then RUN with load_count=3.
REQ-035 img_valid gaps of 3 cycles between words -> strobes are delayed by the same gaps, never duplicated, and the final image is unchanged.
REQ-036 RUN with in_data=0x00AB, cpu_read held 4 cycles -> io=0x00AB for 4 cycles, in_ready pulsed once.
REQ-037 cpu_read with in_valid=0 -> io=0 and underflow=1; cpu_write with io_in=0xBEEF -> single out_valid pulse, out_data=0xBEEF.
REQ-038 257 words without last -> err=1, 256 pgrm_data strobes; start -> CLR with load_count=0.
REQ-039 rst low during DATA -> IDLE with cpu_rst=1 asynchronously; halt in RUN -> done=1.
